// File: rtl/sme_feeder.sv
// sme_feeder: frames 02/03/0A byte records, replays string then pattern as one gapless burst; first char one cycle after the pattern's 0A.
// in_ready drops from burst start until a sme_valid rise; define SME_FEED_TIMEOUT_EN for a 1023-cycle WAIT timeout.
module sme_feeder #(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] chardata,
   output logic       isstring,
   output logic       ispattern,
   input  logic       sme_valid,
   output logic       busy,
   output logic       err
);
   localparam int SAW = $clog2(STR_MAX);
   localparam int PAW = $clog2(PAT_MAX);
   localparam logic [5:0] STR_LIM = 6'(STR_MAX);
   localparam logic [3:0] PAT_LIM = 4'(PAT_MAX);

   typedef enum logic [2:0] {S_IDLE, S_RX_STR, S_RX_PAT, S_TX_STR, S_TX_PAT, S_WAIT} state_e;

   state_e     state_q, state_d;
   logic [5:0] s_wr_q, s_wr_d, s_len_q, s_len_d, rd_q, rd_d;
   logic [3:0] p_wr_q, p_wr_d, p_len_q, p_len_d;
   logic       str_pend_q, str_pend_d, str_ok_q, str_ok_d;
   logic       err_q, err_d, isstring_q, isstring_d, ispattern_q, ispattern_d;
   logic [7:0] chardata_q, chardata_d;
   logic       sme_valid_q;
   logic       str_we, pat_we, accept;
   logic [7:0] str_mem [STR_MAX];
   logic [7:0] pat_mem [PAT_MAX];
`ifdef SME_FEED_TIMEOUT_EN
   logic [9:0] to_cnt_q, to_cnt_d;
`endif

   assign in_ready  = (state_q == S_IDLE) || (state_q == S_RX_STR) || (state_q == S_RX_PAT);
   assign busy      = (state_q == S_TX_STR) || (state_q == S_TX_PAT) || (state_q == S_WAIT);
   assign accept    = in_valid && in_ready;
   assign chardata  = chardata_q;
   assign isstring  = isstring_q;
   assign ispattern = ispattern_q;
   assign err       = err_q;

   always_comb begin
      state_d     = state_q;
      s_wr_d      = s_wr_q;
      p_wr_d      = p_wr_q;
      s_len_d     = s_len_q;
      p_len_d     = p_len_q;
      rd_d        = rd_q;
      str_pend_d  = str_pend_q;
      str_ok_d    = str_ok_q;
      err_d       = 1'b0;
      chardata_d  = 8'h00;
      isstring_d  = 1'b0;
      ispattern_d = 1'b0;
      str_we      = 1'b0;
      pat_we      = 1'b0;
`ifdef SME_FEED_TIMEOUT_EN
      to_cnt_d    = (state_q == S_WAIT) ? to_cnt_q + 10'd1 : 10'd0;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept && in_data == 8'h02) begin
               state_d = S_RX_STR;
               s_wr_d  = '0;
            end else if (accept && in_data == 8'h03) begin
               state_d = S_RX_PAT;
               p_wr_d  = '0;
            end
         end
         S_RX_STR, S_RX_PAT: begin
            if (accept) begin
               if (in_data == 8'h02) begin
                  err_d   = 1'b1;
                  state_d = S_RX_STR;
                  s_wr_d  = '0;
               end else if (in_data == 8'h03) begin
                  err_d   = 1'b1;
                  state_d = S_RX_PAT;
                  p_wr_d  = '0;
               end else if (in_data == 8'h0A) begin
                  state_d = S_IDLE;
                  if (state_q == S_RX_STR) begin
                     if (s_wr_q == '0) begin
                        err_d = 1'b1;
                     end else begin
                        s_len_d    = s_wr_q;
                        str_pend_d = 1'b1;
                        str_ok_d   = 1'b1;
                     end
                  end else if (p_wr_q == '0 || !str_ok_q) begin
                     err_d = 1'b1;
                  end else begin
                     // First character goes out on this same edge.
                     p_len_d = p_wr_q;
                     rd_d    = 6'd1;
                     if (str_pend_q) begin
                        state_d    = S_TX_STR;
                        chardata_d = str_mem[0];
                        isstring_d = 1'b1;
                     end else begin
                        state_d     = S_TX_PAT;
                        chardata_d  = pat_mem[0];
                        ispattern_d = 1'b1;
                     end
                  end
               end else if (state_q == S_RX_STR) begin
                  if (s_wr_q < STR_LIM) begin
                     str_we = 1'b1;
                     s_wr_d = s_wr_q + 6'd1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else begin
                  if (p_wr_q < PAT_LIM) begin
                     pat_we = 1'b1;
                     p_wr_d = p_wr_q + 4'd1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         S_TX_STR: begin
            if (rd_q < s_len_q) begin
               chardata_d = str_mem[rd_q[SAW-1:0]];
               isstring_d = 1'b1;
               rd_d       = rd_q + 6'd1;
            end else begin
               chardata_d  = pat_mem[0];
               ispattern_d = 1'b1;
               rd_d        = 6'd1;
               state_d     = S_TX_PAT;
               str_pend_d  = 1'b0;
            end
         end
         S_TX_PAT: begin
            if (rd_q < {2'b00, p_len_q}) begin
               chardata_d  = pat_mem[rd_q[PAW-1:0]];
               ispattern_d = 1'b1;
               rd_d        = rd_q + 6'd1;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // Only a fresh rise counts; a level left high from the last result is ignored.
            if (sme_valid && !sme_valid_q) begin
               state_d = S_IDLE;
            end
`ifdef SME_FEED_TIMEOUT_EN
            else if (to_cnt_q == 10'd1022) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         s_wr_q      <= '0;
         p_wr_q      <= '0;
         s_len_q     <= '0;
         p_len_q     <= '0;
         rd_q        <= '0;
         str_pend_q  <= 1'b0;
         str_ok_q    <= 1'b0;
         err_q       <= 1'b0;
         chardata_q  <= 8'h00;
         isstring_q  <= 1'b0;
         ispattern_q <= 1'b0;
         sme_valid_q <= 1'b0;
`ifdef SME_FEED_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         s_wr_q      <= s_wr_d;
         p_wr_q      <= p_wr_d;
         s_len_q     <= s_len_d;
         p_len_q     <= p_len_d;
         rd_q        <= rd_d;
         str_pend_q  <= str_pend_d;
         str_ok_q    <= str_ok_d;
         err_q       <= err_d;
         chardata_q  <= chardata_d;
         isstring_q  <= isstring_d;
         ispattern_q <= ispattern_d;
         sme_valid_q <= sme_valid;
`ifdef SME_FEED_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (str_we) str_mem[s_wr_q[SAW-1:0]] <= in_data;
      if (pat_we) pat_mem[p_wr_q[PAW-1:0]] <= in_data;
   end
endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: record framing, burst shape, truncation, WAIT handshake and reset.
module tb_sme_feeder;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] chardata;
   logic       isstring;
   logic       ispattern;
   logic       sme_valid = 1'b0;
   logic       busy;
   logic       err;

   int n_asrt = 0;
   int n_fail = 0;
   logic [9:0] exp_b [64];

   sme_feeder dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
      .sme_valid(sme_valid), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asrt++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One byte presented for exactly one edge; err for that byte is visible right after.
   task automatic send(input logic [7:0] b, input logic exp_err, input string tag);
      in_data  = b;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk(tag, 32'(err), 32'(exp_err));
   endtask

   // Called right after the pattern's 0A edge; checks n burst cycles then the quiet WAIT state.
   task automatic chk_burst(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s[%0d]", tag, i), 32'({isstring, ispattern, chardata}), 32'(exp_b[i]));
         cyc();
      end
      chk({tag, "_end"}, 32'({isstring, ispattern, chardata, busy, in_ready}), 32'({10'h000, 1'b1, 1'b0}));
   endtask

   task automatic release_wait(input string tag);
      sme_valid = 1'b0;
      cyc();
      sme_valid = 1'b1;
      cyc();
      chk(tag, 32'({in_ready, busy}), 32'(2'b10));
   endtask

   initial begin
      logic got_err;
      int   k;
      int   nerr;

      #12;
      chk("rst_outputs", 32'({in_ready, busy, err, isstring, ispattern, chardata}), 32'({5'b10000, 8'h00}));
      @(negedge clk);
      reset = 1'b0;
      cyc();

      // Pattern before any string was committed.
      send(8'h03, 1'b0, "np_03");
      send(8'h78, 1'b0, "np_x");
      send(8'h0A, 1'b1, "np_0a_err");
      cyc();
      chk("np_after", 32'({err, in_ready, busy, isstring, ispattern}), 32'(5'b01000));

      // String "abc" then pattern "bc".
      send(8'h02, 1'b0, "t1_02");
      send(8'h61, 1'b0, "t1_a");
      send(8'h62, 1'b0, "t1_b");
      send(8'h63, 1'b0, "t1_c");
      send(8'h0A, 1'b0, "t1_s0a");
      send(8'h03, 1'b0, "t1_03");
      send(8'h62, 1'b0, "t1_pb");
      send(8'h63, 1'b0, "t1_pc");
      send(8'h0A, 1'b0, "t1_p0a");
      exp_b[0] = {2'b10, 8'h61};
      exp_b[1] = {2'b10, 8'h62};
      exp_b[2] = {2'b10, 8'h63};
      exp_b[3] = {2'b01, 8'h62};
      exp_b[4] = {2'b01, 8'h63};
      chk_burst(5, "t1");
      for (int i = 0; i < 5; i++) cyc();
      chk("t1_wait_rdy", 32'(in_ready), 32'(0));
      release_wait("t1_release");

      // Pattern-only burst while sme_valid stays high.
      send(8'h03, 1'b0, "t2_03");
      send(8'h5E, 1'b0, "t2_caret");
      send(8'h61, 1'b0, "t2_a");
      send(8'h0A, 1'b0, "t2_0a");
      exp_b[0] = {2'b01, 8'h5E};
      exp_b[1] = {2'b01, 8'h61};
      chk_burst(2, "t2");
      got_err = 1'b0;
      k = 0;
      while (k < 1100 && !got_err) begin
         k++;
         cyc();
         got_err = err;
      end
`ifdef SME_FEED_TIMEOUT_EN
      chk("t2_timeout_cycle", 32'(k), 32'(1023));
      chk("t2_timeout_rdy", 32'({got_err, in_ready, busy}), 32'(3'b110));
`else
      chk("t2_stuck_wait", 32'({got_err, in_ready, busy}), 32'(3'b001));
`endif
      release_wait("t2_release");

      // 35-byte string truncates to 32 with three err pulses.
      send(8'h02, 1'b0, "t4_02");
      nerr = 0;
      for (int i = 0; i < 35; i++) begin
         send(8'(8'h20 + i), (i >= 32), $sformatf("t4_d%0d", i));
         if (err) nerr++;
      end
      chk("t4_nerr", 32'(nerr), 32'(3));
      send(8'h0A, 1'b0, "t4_s0a");
      send(8'h03, 1'b0, "t4_03");
      send(8'h7A, 1'b0, "t4_z");
      send(8'h0A, 1'b0, "t4_p0a");
      for (int i = 0; i < 32; i++) exp_b[i] = {2'b10, 8'(8'h20 + i)};
      exp_b[32] = {2'b01, 8'h7A};
      chk_burst(33, "t4");
      release_wait("t4_release");

      // in_valid toggling while sending; burst must still be gapless.
      send(8'h02, 1'b0, "t5_02"); cyc();
      send(8'h70, 1'b0, "t5_p");  cyc();
      send(8'h71, 1'b0, "t5_q");  cyc();
      send(8'h0A, 1'b0, "t5_s0a"); cyc();
      send(8'h03, 1'b0, "t5_03"); cyc();
      send(8'h71, 1'b0, "t5_pq"); cyc();
      send(8'h0A, 1'b0, "t5_p0a");
      exp_b[0] = {2'b10, 8'h70};
      exp_b[1] = {2'b10, 8'h71};
      exp_b[2] = {2'b01, 8'h71};
      chk_burst(3, "t5");
      release_wait("t5_release");

      // Empty string, then a string record abandoned by 03.
      send(8'h02, 1'b0, "t6_02");
      send(8'h0A, 1'b1, "t6_empty_err");
      send(8'h02, 1'b0, "t6_02b");
      send(8'h6D, 1'b0, "t6_m");
      send(8'h03, 1'b1, "t6_abandon_err");
      send(8'h6B, 1'b0, "t6_k");
      send(8'h0A, 1'b0, "t6_p0a");
      exp_b[0] = {2'b01, 8'h6B};
      chk_burst(1, "t6");
      release_wait("t6_release");

      // Reset in the middle of a string burst.
      send(8'h02, 1'b0, "t7_02");
      send(8'h61, 1'b0, "t7_a");
      send(8'h62, 1'b0, "t7_b");
      send(8'h0A, 1'b0, "t7_s0a");
      send(8'h03, 1'b0, "t7_03");
      send(8'h62, 1'b0, "t7_pb");
      send(8'h0A, 1'b0, "t7_p0a");
      chk("t7_first", 32'({isstring, ispattern, chardata}), 32'({2'b10, 8'h61}));
      #2;
      reset = 1'b1;
      #1;
      chk("t7_async_drop", 32'({isstring, ispattern, chardata, busy, in_ready}), 32'({10'h000, 2'b01}));
      @(negedge clk);
      reset = 1'b0;
      cyc();
      send(8'h03, 1'b0, "t7_np03");
      send(8'h62, 1'b0, "t7_npb");
      send(8'h0A, 1'b1, "t7_np_err");
      cyc();
      chk("t7_no_burst", 32'({isstring, ispattern, in_ready, busy}), 32'(4'b0010));

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule

// File: doc/sme_feeder.md
# sme_feeder

Framing and burst stage directly upstream of the string-matching engine. Accepts a byte stream with valid/ready handshake, assembles string and pattern records into local buffers, and replays them to the matcher as the contiguous `chardata`/`isstring`/`ispattern` bursts it requires. It then holds off further input until the matcher reports a result.

## Interface
- `STR_MAX`, default 32: string buffer depth in characters.
- `PAT_MAX`, default 8: pattern buffer depth in characters.
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high.
- `in_data`  in  8: input byte.
- `in_valid`  in  1: `in_data` valid.
- `in_ready`  out  1: byte accepted when `in_valid & in_ready`.
- `chardata`  out  8: character to matcher, registered.
- `isstring`  out  1: `chardata` is a string character.
- `ispattern`  out  1: `chardata` is a pattern character.
- `sme_valid`  in  1: matcher result-valid (level).
- `busy`  out  1: a burst is in flight or a result is awaited.
- `err`  out  1: one-cycle error pulse.

## Operation
- Control bytes:
  - 0x02 starts a string record.
  - 0x03 starts a pattern record.
  - 0x0A ends the current record.
  - All other bytes are data inside a record and are dropped outside one.
  - 0x02/0x03 received inside a record abandons that record (`err` pulse) and starts the new one.
- States: IDLE, RX_STR, RX_PAT, TX_STR, TX_PAT, WAIT.
  - IDLE: 0x02 -> RX_STR (clear `s_wr`); 0x03 -> RX_PAT (clear `p_wr`).
  - RX_STR: data is written at `str[s_wr]` and `s_wr` increments. Data beyond STR_MAX is dropped with an `err` pulse, and the record is kept truncated. On 0x0A: if `s_wr==0`, `err` and discard; otherwise commit `s_len=s_wr`, set `str_pend`. -> IDLE.
  - RX_PAT: same rules against PAT_MAX. On 0x0A:
    - `p_wr==0`: `err`, -> IDLE.
    - No string committed since reset: `err`, -> IDLE.
    - Otherwise commit `p_len`; go to TX_STR if `str_pend`, else TX_PAT.
  - TX_STR: emits `str[0..s_len-1]` one per cycle with `isstring=1`. After the last character, enters TX_PAT in the following cycle with no gap. Clears `str_pend`.
  - TX_PAT: emits `pat[0..p_len-1]` with `ispattern=1`. After the last character -> WAIT, with `isstring`/`ispattern` low.
  - WAIT: leaves on a rising edge of `sme_valid` (registered copy low, current high) -> IDLE. A level-high `sme_valid` left over from the previous result is ignored.
- `in_ready` = 1 in IDLE/RX_STR/RX_PAT and 0 in TX_STR/TX_PAT/WAIT. It is decoded from the state register.
- `busy` = 1 in TX_STR/TX_PAT/WAIT.
- `isstring` and `ispattern` are never high in the same cycle. `chardata` = 0 whenever both are low.
- Counters `s_wr`/`p_wr` are 6/4 bits, saturating at STR_MAX/PAT_MAX. They never wrap.

## Timing
- Reset values: state IDLE; `chardata` 0; `isstring` 0; `ispattern` 0; `err` 0; `busy` 0; `str_pend` 0; string-committed flag 0. `in_ready` is 1 after reset (IDLE).
- Reset mid-burst drops `isstring`/`ispattern` asynchronously and discards both buffers.
- Latency: the first burst character is on the outputs in the cycle after the clock edge that accepts the pattern's 0x0A.
- Burst length is `s_len+p_len` cycles when a string is pending, else `p_len` cycles.
- `err` is high for exactly one cycle per offending byte or record end.

## Configuration
- `SME_FEED_TIMEOUT_EN` defined:
  - A 10-bit counter runs in WAIT.
  - After 1023 cycles without a `sme_valid` rising edge: `err` pulse, -> IDLE. The string stays committed.
- Not defined: WAIT lasts indefinitely and no counter is synthesized.

## Test plan
- Bytes 02 'a' 'b' 'c' 0A 03 'b' 'c' 0A -> `isstring` high 3 cycles (61,62,63), then immediately `ispattern` high 2 cycles (62,63). `in_ready`=0 until a `sme_valid` rise, then 1.
- After the above, 03 '^' 'a' 0A -> `ispattern` only, 2 cycles (5E,61), no string burst.
- 03 'x' 0A straight after reset -> `err` pulse, no burst, `in_ready` stays 1.
- String of 35 data bytes -> 3 `err` pulses; the following burst has exactly 32 `isstring` cycles.
- `in_valid` toggling every other cycle while sending a record -> burst still contiguous with no idle cycle between characters.
- `sme_valid` held high from the previous result through a new burst and never re-rising -> stays in WAIT. With `SME_FEED_TIMEOUT_EN` defined: `err` 1023 cycles after WAIT entry, then `in_ready`=1.
